// File: rtl/axi_stream_master_tx.sv
// AXI4-Stream transmit end: buffers 128-bit blocks from the core and
// serialises each one into four 32-bit beats on m00_axis.
module axi_stream_master_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH          = 128,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  blk_valid,
    output logic                                  blk_ready,
    input  logic [BLOCK_WIDTH-1:0]                blk_data,
    input  logic                                  blk_last,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]       m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]     m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  busy
);

    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int BW = BLOCK_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = BW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [EW-1:0]  head;
    logic [BW-1:0]  sreg;
    logic           slast;
    logic [1:0]     wcnt;
    logic           push;
    logic           pop;
    logic           hs;
    logic           empty;

    assign empty          = (fifo_count == '0);
    assign blk_ready      = (fifo_count != FULL);
    assign push           = blk_valid && blk_ready;
    assign hs             = m00_axis_tvalid && m00_axis_tready;
    assign head           = mem[rd_ptr];
    assign m00_axis_tstrb = '1;
    assign busy           = !empty || (state == SEND);

    // Refill straight from the FIFO on the last beat so back-to-back
    // blocks stream without a bubble.
    assign pop = !empty && ((state == IDLE) || (hs && wcnt == 2'd3));

    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            mem[wr_ptr] <= {blk_last, blk_data};
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // sreg holds the words not yet presented, most significant first.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state           <= IDLE;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            sreg            <= '0;
            slast           <= 1'b0;
            wcnt            <= '0;
        end else if (pop) begin
            state           <= SEND;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= head[BW-1 -: DW];
            sreg            <= {head[BW-DW-1:0], {DW{1'b0}}};
            slast           <= head[BW];
            wcnt            <= '0;
        end else if (hs) begin
            if (wcnt == 2'd3) begin
                state           <= IDLE;
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
            end else begin
                wcnt           <= wcnt + 2'd1;
                m00_axis_tdata <= sreg[BW-1 -: DW];
                sreg           <= {sreg[BW-DW-1:0], {DW{1'b0}}};
                m00_axis_tlast <= (wcnt == 2'd2) && slast;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_master_tx.sv
// Directed bench for axi_stream_master_tx with a beat-queue reference
// model checked on every handshake.
module tb_axi_stream_master_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [127:0] blk_data = '0;
    logic         blk_last = 1'b0;
    logic         tvalid;
    logic         tready = 1'b0;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic [2:0]   fifo_count;
    logic         busy;

    int npass = 0;
    int ncheck = 0;
    int nbeats = 0;
    logic [32:0] exp_q[$];

    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = '0;

    axi_stream_master_tx dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .blk_valid        (blk_valid),
        .blk_ready        (blk_ready),
        .blk_data         (blk_data),
        .blk_last         (blk_last),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tready  (tready),
        .m00_axis_tdata   (tdata),
        .m00_axis_tstrb   (tstrb),
        .m00_axis_tlast   (tlast),
        .fifo_count       (fifo_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        ncheck++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference model: every accepted block becomes four queued beats.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            exp_q.delete();
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_tvalid", {31'b0, tvalid}, 1);
                chk("hold_tdata", tdata, pd);
                chk("hold_tlast", {31'b0, tlast}, {31'b0, pl});
            end
            chk("ready_rule", {31'b0, blk_ready},
                {31'b0, fifo_count < 3'd4});
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    ncheck++;
                    $display("FAIL beat_unexpected: got %h expected none", tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", tdata, e[31:0]);
                    chk("beat_last", {31'b0, tlast}, {31'b0, e[32]});
                end
                nbeats <= nbeats + 1;
            end
            if (blk_valid && blk_ready) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({blk_last && (k == 3),
                                     blk_data[127-32*k -: 32]});
            end
            pv <= tvalid;
            pr <= tready;
            pd <= tdata;
            pl <= tlast;
        end
    end

    task automatic push_blk(input logic [127:0] d, input logic l);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = l;
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", {31'b0, exp_q.size() == 0 && !busy}, 1);
    endtask

    function automatic logic [127:0] mkblk(input int i);
        logic [127:0] d;
        for (int k = 0; k < 4; k++)
            d[127-32*k -: 32] = 32'hB200_0000 + 32'(i * 4 + k);
        return d;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        logic [6:0] pat;
        pat = 7'b1010011;

        // Reset state
        #2;
        chk("rst_tvalid", {31'b0, tvalid}, 0);
        chk("rst_tlast", {31'b0, tlast}, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_ready", {31'b0, blk_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_count", {29'b0, fifo_count}, 0);
        chk("tstrb", {28'b0, tstrb}, 32'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single block, latency and tlast placement
        tready = 1'b1;
        push_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        chk("t1_e_tvalid", {31'b0, tvalid}, 0);
        chk("t1_e_count", {29'b0, fifo_count}, 1);
        chk("t1_e_busy", {31'b0, busy}, 1);
        @(posedge clk); #1;
        chk("t1_b0_tvalid", {31'b0, tvalid}, 1);
        chk("t1_b0_data", tdata, 32'h00112233);
        chk("t1_b0_last", {31'b0, tlast}, 0);
        chk("t1_b0_count", {29'b0, fifo_count}, 0);
        @(posedge clk); #1;
        chk("t1_b1_data", tdata, 32'h44556677);
        @(posedge clk); #1;
        chk("t1_b2_data", tdata, 32'h8899AABB);
        chk("t1_b2_last", {31'b0, tlast}, 0);
        @(posedge clk); #1;
        chk("t1_b3_data", tdata, 32'hCCDDEEFF);
        chk("t1_b3_last", {31'b0, tlast}, 1);
        @(posedge clk); #1;
        chk("t1_idle_tvalid", {31'b0, tvalid}, 0);
        chk("t1_idle_busy", {31'b0, busy}, 0);

        // Six pushes against a stalled sink, then full-rate drain
        tready = 1'b0;
        for (int i = 0; i < 6; i++)
            push_blk(mkblk(i), (i == 1) || (i == 4));
        chk("t2_count", {29'b0, fifo_count}, 4);
        chk("t2_ready", {31'b0, blk_ready}, 0);
        chk("t2_tvalid", {31'b0, tvalid}, 1);
        chk("t2_b0", tdata, 32'hB200_0000);
        chk("t2_qsize", exp_q.size(), 20);
        s = nbeats;
        tready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t2_no_gaps", nbeats - s, 20);
        chk("t2_idle", {31'b0, busy}, 0);

        // Three-block packet under a toggling tready
        tready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_blk(mkblk(10 + i), i == 2);
        s = nbeats;
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            tready = pat[6 - (i % 7)];
            @(posedge clk); #1;
        end
        tready = 1'b1;
        chk("t3_beats", nbeats - s, 12);
        drain(20);

        // Push offered while full, in the same cycle as a pop
        tready = 1'b0;
        s = nbeats;
        for (int i = 0; i < 5; i++)
            push_blk(mkblk(20 + i), i == 4);
        chk("t4_full", {29'b0, fifo_count}, 4);
        tready    = 1'b1;
        blk_valid = 1'b1;
        blk_data  = mkblk(30);
        blk_last  = 1'b1;
        for (int h = 1; h <= 3; h++) begin
            @(posedge clk); #1;
            chk("t4_ready_low", {31'b0, blk_ready}, 0);
        end
        @(posedge clk); #1;
        chk("t4_pop_count", {29'b0, fifo_count}, 3);
        chk("t4_pop_ready", {31'b0, blk_ready}, 1);
        @(posedge clk); #1;
        chk("t4_push_count", {29'b0, fifo_count}, 4);
        blk_valid = 1'b0;
        drain(60);
        chk("t4_beats", nbeats - s, 24);

        // Reset while beat 2 of a block is presented
        tready = 1'b0;
        push_blk(mkblk(40), 1'b1);
        push_blk(mkblk(41), 1'b1);
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        chk("t5_beat2", tdata, 32'hB200_00A1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_tvalid", {31'b0, tvalid}, 0);
        chk("t5_tdata", tdata, 0);
        chk("t5_count", {29'b0, fifo_count}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_post_busy", {31'b0, busy}, 0);
        tready = 1'b1;
        push_blk(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b1);
        @(posedge clk); #1;
        chk("t5_new_b0", tdata, 32'hDEADBEEF);
        drain(20);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
